mem_bus_ctrl: RTL and testbench
===============================

# mem_bus_ctrl

Memory and I/O bus controller directly downstream of the 4-bit CPU core. It decodes every CPU bus cycle. Addresses outside the MMIO page pass through to the external program/data memory interface. Addresses inside the page hit on-chip resources: a 16x4 scratch RAM, a 4-bit GPIO port and a 12-bit prescaled timer with a sticky overflow flag. Read data returns combinationally, so the CPU samples it at the next edge with zero wait states.

## Interface
- PRESCALE, 16: timer tick period in clk cycles; legal range 1..256.
- MMIO_BASE, 12'hF00: base of the 32-nibble MMIO page; only bits [11:5] are compared.

- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- cpu_addr  in  12  CPU bus address.
- cpu_rw  in  1  1 = write cycle, 0 = read cycle.
- cpu_wdata  in  4  CPU write data.
- cpu_rdata  out  4  read data to CPU; combinational from cpu_addr.
- ext_addr  out  12  external memory address; equals cpu_addr.
- ext_we  out  1  one-cycle external write strobe.
- ext_wdata  out  4  external write data; equals cpu_wdata.
- ext_rdata  in  4  external memory read data.
- gpio_in  in  4  asynchronous input pins.
- gpio_out  out  4  output latch.
- gpio_oe  out  4  per-pin output enable, 1 = drive.

## Operation
- MMIO hit when cpu_addr[11:5] == MMIO_BASE[11:5]. Otherwise the access goes external and cpu_rdata = ext_rdata.
- MMIO map, by offset cpu_addr[4:0]:
  - 0x00-0x0F: RAM, read/write.
  - 0x10: GPIO_OUT, read/write.
  - 0x11: GPIO_IN, read-only; synchronized value.
  - 0x12: GPIO_OE, read/write.
  - 0x13: TMR0, nibble [3:0].
  - 0x14: TMR1, nibble [7:4]; reads return the shadow.
  - 0x15: TMR2, nibble [11:8]; reads return the shadow.
  - 0x16: CTRL; bit0 = enable, bits [3:1] read 0.
  - 0x17: STAT; bit0 = overflow, sticky, write-1-to-clear.
  - 0x18-0x1F: unmapped; reads return 0, writes are ignored.
- CPU write protocol: the CPU raises cpu_rw with a stable address one cycle before cpu_wdata becomes valid. cpu_rw then stays high until the CPU's next fetch.
- Registered copies rw_q and addr_q are kept. The write strobe is wr = cpu_rw & rw_q & (cpu_addr == addr_q).
  - Exactly one commit per CPU store, using the second-cycle data.
  - Further cycles with the same rw and address re-commit the same data, which is harmless. STAT is the exception: W1C makes repeats idempotent.
- ext_we = wr & ~MMIO hit.
- GPIO_IN: two-flop synchronizer, so a pin change is visible 2 cycles later.
- Timer:
  - Prescale counter pc runs 0..PRESCALE-1 while CTRL.enable = 1. tick is asserted when pc == PRESCALE-1, after which pc wraps to 0.
  - pc clears whenever enable = 0.
  - On tick the 12-bit counter increments. 0xFFF -> 0x000 sets STAT.overflow.
- Timer snapshot: the first read cycle of TMR0 (cpu_rw = 0, offset 0x13, and previous cycle not (read, 0x13)) copies counter[11:4] into shadow[7:0].
  - The TMR0 read itself returns the live counter[3:0].
  - Reading TMR0, then TMR1, then TMR2 gives a coherent 12-bit value.
- Simultaneous events:
  - A CPU write to a TMR nibble on a tick cycle: the written nibble takes the written value and the other nibbles hold. No increment that cycle.
  - STAT W1C on the same cycle as an overflow: the set wins.
- Reset values: gpio_out = 0, gpio_oe = 0, RAM all 0, counter = 0, shadow = 0, pc = 0, CTRL = 0, STAT = 0, synchronizer = 0, rw_q = 0, addr_q = 0.
  - With cpu_rw = 0, ext_we = 0.
  - cpu_rdata follows decode immediately.
- Reset asserted mid-store: the store is abandoned, all state is cleared, and the commit is not performed.

## Timing
- Read latency: 0 cycles; cpu_rdata is combinational from cpu_addr and sampled by the CPU at the next edge.
- Write commit: at the end of the second consecutive cycle with cpu_rw = 1 on the same address. The target register shows the new value in the following cycle.
- ext_we: high for one cycle coincident with wr; ext_addr and ext_wdata are valid in that cycle.
- Timer period: exactly PRESCALE clk cycles per increment from enable.
  - The first increment occurs PRESCALE cycles after the edge that writes enable = 1.
- STAT.overflow: visible the cycle after the wrapping tick.

## Test plan
- Reset, then a read of 0x000 with ext_rdata = 4'hA: cpu_rdata = 4'hA; gpio_out = 0, gpio_oe = 0, ext_we = 0.
- Store 4'h5 to 0xF07 (rw = 1 for 1 cycle with stale data 4'h3, then with 4'h5), then read 0xF07: returns 4'h5. RAM never holds 4'h3; ext_we stays 0.
- Store to 0x123 with data 4'hC: ext_we is a single-cycle pulse with ext_addr = 0x123 and ext_wdata = 4'hC.
- Timer with PRESCALE = 4:
  - Preload TMR2 = F, TMR1 = F, TMR0 = E, then write CTRL = 1.
  - Counter reaches 0xFFF after 4 cycles and 0x000 after 8; STAT reads 1.
  - W1C STAT on the overflow cycle leaves it 1; a later W1C clears it.
- Snapshot coherency: with the counter at 0x0FF about to tick, read TMR0 (F), then TMR1 and TMR2 after the tick: returns 0x0FF, not 0x1xx.
- gpio_in toggles 0 -> 9: GPIO_IN reads 9 exactly 2 cycles later. Write GPIO_OE = 4'hF and GPIO_OUT = 4'h6: gpio_oe = F and gpio_out = 6. Unmapped 0xF1C reads 0.

Source files
------------

// File: rtl/mem_bus_if.sv
// mem_bus_if: CPU-side and external-memory-side bus of mem_bus_ctrl.
//   cpu_addr/cpu_rw/cpu_wdata : CPU cycle request (rw=1 write)
//   cpu_rdata                 : read data back to the CPU
//   ext_addr/ext_we/ext_wdata : external memory request
//   ext_rdata                 : external memory read data
// master: the environment (CPU plus external memory); slave: the controller.
interface mem_bus_if;
  logic [11:0] cpu_addr;
  logic        cpu_rw;
  logic [3:0]  cpu_wdata;
  logic [3:0]  cpu_rdata;
  logic [11:0] ext_addr;
  logic        ext_we;
  logic [3:0]  ext_wdata;
  logic [3:0]  ext_rdata;

  modport master (
    output cpu_addr, cpu_rw, cpu_wdata, ext_rdata,
    input  cpu_rdata, ext_addr, ext_we, ext_wdata
  );

  modport slave (
    input  cpu_addr, cpu_rw, cpu_wdata, ext_rdata,
    output cpu_rdata, ext_addr, ext_we, ext_wdata
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: decodes 4-bit CPU bus cycles. A 32-nibble MMIO page at
// MMIO_BASE holds a 16x4 scratch RAM, a GPIO port and a 12-bit prescaled
// timer; everything else passes through to external memory.
//   clk, rst_n        : clock, synchronous active-low reset
//   bus (slave)       : CPU and external memory bus, see mem_bus_if
//   gpio_in           : asynchronous input pins
//   gpio_out, gpio_oe : output latch and per-pin drive enable
module mem_bus_ctrl #(
  parameter int unsigned PRESCALE  = 16,
  parameter logic [11:0] MMIO_BASE = 12'hF00
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_bus_if.slave   bus,
  input  logic [3:0] gpio_in,
  output logic [3:0] gpio_out,
  output logic [3:0] gpio_oe
);

  localparam int unsigned    PCW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PCW-1:0] PC_LAST = PCW'(PRESCALE - 1);

  typedef enum logic [4:0] {
    OFF_GPIO_OUT = 5'h10,
    OFF_GPIO_IN  = 5'h11,
    OFF_GPIO_OE  = 5'h12,
    OFF_TMR0     = 5'h13,
    OFF_TMR1     = 5'h14,
    OFF_TMR2     = 5'h15,
    OFF_CTRL     = 5'h16,
    OFF_STAT     = 5'h17
  } mmio_off_e;

  localparam logic [11:0] TMR0_ADDR = {MMIO_BASE[11:5], OFF_TMR0};

  logic           rw_q, rw_d;
  logic [11:0]    addr_q, addr_d;
  logic [3:0]     ram_q [16];
  logic [3:0]     ram_d [16];
  logic [3:0]     gpio_out_q, gpio_out_d;
  logic [3:0]     gpio_oe_q, gpio_oe_d;
  logic [3:0]     sync1_q, sync1_d;
  logic [3:0]     sync2_q, sync2_d;
  logic           en_q, en_d;
  logic           ovf_q, ovf_d;
  logic [11:0]    cnt_q, cnt_d;
  logic [7:0]     shadow_q, shadow_d;
  logic [PCW-1:0] pc_q, pc_d;

  logic       hit;
  logic [4:0] off;
  logic       wr;
  logic       mmio_wr;
  logic       tmr_wr;
  logic       tick;
  logic       snap;

  always_comb begin
    hit     = (bus.cpu_addr[11:5] == MMIO_BASE[11:5]);
    off     = bus.cpu_addr[4:0];
    // Second consecutive write cycle on the same address carries valid data.
    wr      = bus.cpu_rw & rw_q & (bus.cpu_addr == addr_q);
    mmio_wr = wr & hit;
    tmr_wr  = mmio_wr & ((off == OFF_TMR0) | (off == OFF_TMR1) | (off == OFF_TMR2));
    tick    = en_q & (pc_q == PC_LAST);
    // Only the first cycle of a TMR0 read latches the upper nibbles, so a
    // held read does not keep refreshing the shadow.
    snap    = ~bus.cpu_rw & hit & (off == OFF_TMR0) &
              ~(~rw_q & (addr_q == TMR0_ADDR));
  end

  assign bus.ext_addr  = bus.cpu_addr;
  assign bus.ext_wdata = bus.cpu_wdata;
  // A store caught by reset is abandoned, including its external strobe.
  assign bus.ext_we    = wr & ~hit & rst_n;
  assign gpio_out      = gpio_out_q;
  assign gpio_oe       = gpio_oe_q;

  always_comb begin
    rw_d       = bus.cpu_rw;
    addr_d     = bus.cpu_addr;
    ram_d      = ram_q;
    gpio_out_d = gpio_out_q;
    gpio_oe_d  = gpio_oe_q;
    sync1_d    = gpio_in;
    sync2_d    = sync1_q;
    en_d       = en_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    pc_d       = (~en_q | tick) ? '0 : pc_q + 1'b1;

    if (mmio_wr) begin
      if (off[4] == 1'b0) begin
        ram_d[off[3:0]] = bus.cpu_wdata;
      end else begin
        case (off)
          OFF_GPIO_OUT: gpio_out_d   = bus.cpu_wdata;
          OFF_GPIO_OE:  gpio_oe_d    = bus.cpu_wdata;
          OFF_TMR0:     cnt_d[3:0]   = bus.cpu_wdata;
          OFF_TMR1:     cnt_d[7:4]   = bus.cpu_wdata;
          OFF_TMR2:     cnt_d[11:8]  = bus.cpu_wdata;
          OFF_CTRL:     en_d         = bus.cpu_wdata[0];
          OFF_STAT:     if (bus.cpu_wdata[0]) ovf_d = 1'b0;
          default:      ;
        endcase
      end
    end

    // Evaluated after the W1C so a coincident overflow leaves the flag set;
    // a CPU write to any timer nibble suppresses the increment.
    if (tick & ~tmr_wr) begin
      cnt_d = cnt_q + 12'd1;
      if (cnt_q == '1) ovf_d = 1'b1;
    end

    if (snap) shadow_d = cnt_q[11:4];
  end

  always_comb begin
    bus.cpu_rdata = '0;
    if (!hit) begin
      bus.cpu_rdata = bus.ext_rdata;
    end else if (off[4] == 1'b0) begin
      bus.cpu_rdata = ram_q[off[3:0]];
    end else begin
      case (off)
        OFF_GPIO_OUT: bus.cpu_rdata = gpio_out_q;
        OFF_GPIO_IN:  bus.cpu_rdata = sync2_q;
        OFF_GPIO_OE:  bus.cpu_rdata = gpio_oe_q;
        OFF_TMR0:     bus.cpu_rdata = cnt_q[3:0];
        OFF_TMR1:     bus.cpu_rdata = shadow_q[3:0];
        OFF_TMR2:     bus.cpu_rdata = shadow_q[7:4];
        OFF_CTRL:     bus.cpu_rdata = {3'b000, en_q};
        OFF_STAT:     bus.cpu_rdata = {3'b000, ovf_q};
        default:      bus.cpu_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rw_q       <= 1'b0;
      addr_q     <= '0;
      ram_q      <= '{default: '0};
      gpio_out_q <= '0;
      gpio_oe_q  <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      en_q       <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      shadow_q   <= '0;
      pc_q       <= '0;
    end else begin
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      ram_q      <= ram_d;
      gpio_out_q <= gpio_out_d;
      gpio_oe_q  <= gpio_oe_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      en_q       <= en_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      pc_q       <= pc_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
module tb_mem_bus_ctrl;
  logic       clk;
  logic       rst_n;
  logic [3:0] gpio_in;
  logic [3:0] gpio_out;
  logic [3:0] gpio_oe;
  int         checks;
  int         errors;

  mem_bus_if bus();

  mem_bus_ctrl #(.PRESCALE(4), .MMIO_BASE(12'hF00)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [11:0] a, input logic [3:0] stale, input logic [3:0] d);
    bus.cpu_addr  = a;
    bus.cpu_rw    = 1'b1;
    bus.cpu_wdata = stale;
    step();
    bus.cpu_wdata = d;
    step();
    bus.cpu_rw    = 1'b0;
    bus.cpu_addr  = 12'h000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cpu_addr = 12'h000; bus.cpu_rw = 1'b0; bus.cpu_wdata = 4'h0;
    bus.ext_rdata = 4'hA; gpio_in = 4'h0;
    step(); step();
    rst_n = 1'b1;
    #1;
    checks++; if (bus.cpu_rdata !== 4'hA) begin errors++; $display("FAIL reset_ext_read got %h exp %h", bus.cpu_rdata, 4'hA); end
    checks++; if (gpio_out !== 4'h0) begin errors++; $display("FAIL reset_gpio_out got %h exp %h", gpio_out, 4'h0); end
    checks++; if (gpio_oe !== 4'h0) begin errors++; $display("FAIL reset_gpio_oe got %h exp %h", gpio_oe, 4'h0); end
    checks++; if (bus.ext_we !== 1'b0) begin errors++; $display("FAIL reset_ext_we got %b exp %b", bus.ext_we, 1'b0); end
    bus.cpu_addr = 12'hF00; #1;
    checks++; if (bus.cpu_rdata !== 4'h0) begin errors++; $display("FAIL reset_ram0 got %h exp %h", bus.cpu_rdata, 4'h0); end
    bus.cpu_addr = 12'hF17; #1;
    checks++; if (bus.cpu_rdata !== 4'h0) begin errors++; $display("FAIL reset_stat got %h exp %h", bus.cpu_rdata, 4'h0); end
    bus.cpu_addr = 12'h000;
  endtask

  task automatic test_ram_store();
    bus.cpu_addr = 12'hF07; bus.cpu_rw = 1'b1; bus.cpu_wdata = 4'h3;
    step();
    bus.cpu_wdata = 4'h5; #1;
    checks++; if (bus.cpu_rdata !== 4'h0) begin errors++; $display("FAIL ram_no_stale got %h exp %h", bus.cpu_rdata, 4'h0); end
    checks++; if (bus.ext_we !== 1'b0) begin errors++; $display("FAIL ram_ext_we got %b exp %b", bus.ext_we, 1'b0); end
    step();
    bus.cpu_rw = 1'b0; #1;
    checks++; if (bus.cpu_rdata !== 4'h5) begin errors++; $display("FAIL ram_read_f07 got %h exp %h", bus.cpu_rdata, 4'h5); end
    store(12'hF0F, 4'h0, 4'hA);
    bus.cpu_addr = 12'hF0F; #1;
    checks++; if (bus.cpu_rdata !== 4'hA) begin errors++; $display("FAIL ram_read_f0f got %h exp %h", bus.cpu_rdata, 4'hA); end
    bus.cpu_addr = 12'hF07; #1;
    checks++; if (bus.cpu_rdata !== 4'h5) begin errors++; $display("FAIL ram_keep_f07 got %h exp %h", bus.cpu_rdata, 4'h5); end
    bus.cpu_addr = 12'h000;
  endtask

  task automatic test_ext_store();
    bus.cpu_addr = 12'h123; bus.cpu_rw = 1'b1; bus.cpu_wdata = 4'h0; #1;
    checks++; if (bus.ext_we !== 1'b0) begin errors++; $display("FAIL ext_we_first got %b exp %b", bus.ext_we, 1'b0); end
    step();
    bus.cpu_wdata = 4'hC; #1;
    checks++; if (bus.ext_we !== 1'b1) begin errors++; $display("FAIL ext_we_pulse got %b exp %b", bus.ext_we, 1'b1); end
    checks++; if (bus.ext_addr !== 12'h123) begin errors++; $display("FAIL ext_addr got %h exp %h", bus.ext_addr, 12'h123); end
    checks++; if (bus.ext_wdata !== 4'hC) begin errors++; $display("FAIL ext_wdata got %h exp %h", bus.ext_wdata, 4'hC); end
    step();
    bus.cpu_rw = 1'b0; #1;
    checks++; if (bus.ext_we !== 1'b0) begin errors++; $display("FAIL ext_we_after got %b exp %b", bus.ext_we, 1'b0); end
    bus.cpu_addr = 12'h000;
  endtask

  task automatic test_timer();
    store(12'hF15, 4'h0, 4'hF);
    store(12'hF14, 4'h0, 4'hF);
    store(12'hF13, 4'h0, 4'hE);
    store(12'hF16, 4'h0, 4'h1);
    bus.cpu_addr = 12'hF13; #1;
    checks++; if (bus.cpu_rdata !== 4'hE) begin errors++; $display("FAIL tmr_start got %h exp %h", bus.cpu_rdata, 4'hE); end
    step(); step(); step();
    checks++; if (bus.cpu_rdata !== 4'hE) begin errors++; $display("FAIL tmr_3cyc got %h exp %h", bus.cpu_rdata, 4'hE); end
    step();
    checks++; if (bus.cpu_rdata !== 4'hF) begin errors++; $display("FAIL tmr_4cyc got %h exp %h", bus.cpu_rdata, 4'hF); end
    bus.cpu_addr = 12'hF16; #1;
    checks++; if (bus.cpu_rdata !== 4'h1) begin errors++; $display("FAIL tmr_ctrl got %h exp %h", bus.cpu_rdata, 4'h1); end
    step(); step();
    // W1C commits on the same edge as the wrap
    store(12'hF17, 4'h0, 4'h1);
    bus.cpu_addr = 12'hF17; #1;
    checks++; if (bus.cpu_rdata !== 4'h1) begin errors++; $display("FAIL tmr_ovf_set_wins got %h exp %h", bus.cpu_rdata, 4'h1); end
    bus.cpu_addr = 12'hF13; #1;
    checks++; if (bus.cpu_rdata !== 4'h0) begin errors++; $display("FAIL tmr_wrap got %h exp %h", bus.cpu_rdata, 4'h0); end
    store(12'hF17, 4'h0, 4'h1);
    bus.cpu_addr = 12'hF17; #1;
    checks++; if (bus.cpu_rdata !== 4'h0) begin errors++; $display("FAIL tmr_ovf_clear got %h exp %h", bus.cpu_rdata, 4'h0); end
    store(12'hF16, 4'h0, 4'h0);
  endtask

  task automatic test_snapshot();
    store(12'hF15, 4'h0, 4'h0);
    store(12'hF14, 4'h0, 4'hF);
    store(12'hF13, 4'h0, 4'hF);
    store(12'hF16, 4'h0, 4'h1);
    step(); step(); step();
    bus.cpu_addr = 12'hF13; #1;
    checks++; if (bus.cpu_rdata !== 4'hF) begin errors++; $display("FAIL snap_tmr0 got %h exp %h", bus.cpu_rdata, 4'hF); end
    step();
    bus.cpu_addr = 12'hF14; #1;
    checks++; if (bus.cpu_rdata !== 4'hF) begin errors++; $display("FAIL snap_tmr1 got %h exp %h", bus.cpu_rdata, 4'hF); end
    step();
    bus.cpu_addr = 12'hF15; #1;
    checks++; if (bus.cpu_rdata !== 4'h0) begin errors++; $display("FAIL snap_tmr2 got %h exp %h", bus.cpu_rdata, 4'h0); end
    step();
    bus.cpu_addr = 12'hF13; #1;
    checks++; if (bus.cpu_rdata !== 4'h0) begin errors++; $display("FAIL snap_tmr0_new got %h exp %h", bus.cpu_rdata, 4'h0); end
    step();
    bus.cpu_addr = 12'hF15; #1;
    checks++; if (bus.cpu_rdata !== 4'h1) begin errors++; $display("FAIL snap_tmr2_new got %h exp %h", bus.cpu_rdata, 4'h1); end
    store(12'hF16, 4'h0, 4'h0);
  endtask

  task automatic test_gpio();
    bus.cpu_addr = 12'hF11; #1;
    checks++; if (bus.cpu_rdata !== 4'h0) begin errors++; $display("FAIL gpio_in_idle got %h exp %h", bus.cpu_rdata, 4'h0); end
    gpio_in = 4'h9;
    step();
    checks++; if (bus.cpu_rdata !== 4'h0) begin errors++; $display("FAIL gpio_in_1cyc got %h exp %h", bus.cpu_rdata, 4'h0); end
    step();
    checks++; if (bus.cpu_rdata !== 4'h9) begin errors++; $display("FAIL gpio_in_2cyc got %h exp %h", bus.cpu_rdata, 4'h9); end
    store(12'hF12, 4'h0, 4'hF);
    store(12'hF10, 4'h0, 4'h6);
    #1;
    checks++; if (gpio_oe !== 4'hF) begin errors++; $display("FAIL gpio_oe got %h exp %h", gpio_oe, 4'hF); end
    checks++; if (gpio_out !== 4'h6) begin errors++; $display("FAIL gpio_out got %h exp %h", gpio_out, 4'h6); end
    bus.cpu_addr = 12'hF10; #1;
    checks++; if (bus.cpu_rdata !== 4'h6) begin errors++; $display("FAIL gpio_out_rd got %h exp %h", bus.cpu_rdata, 4'h6); end
    bus.cpu_addr = 12'hF12; #1;
    checks++; if (bus.cpu_rdata !== 4'hF) begin errors++; $display("FAIL gpio_oe_rd got %h exp %h", bus.cpu_rdata, 4'hF); end
    bus.cpu_addr = 12'h000;
  endtask

  task automatic test_unmapped();
    bus.cpu_addr = 12'hF1C; bus.cpu_rw = 1'b1; bus.cpu_wdata = 4'h7;
    step(); #1;
    checks++; if (bus.ext_we !== 1'b0) begin errors++; $display("FAIL unmapped_ext_we got %b exp %b", bus.ext_we, 1'b0); end
    step();
    bus.cpu_rw = 1'b0; #1;
    checks++; if (bus.cpu_rdata !== 4'h0) begin errors++; $display("FAIL unmapped_f1c got %h exp %h", bus.cpu_rdata, 4'h0); end
    bus.cpu_addr = 12'hF18; #1;
    checks++; if (bus.cpu_rdata !== 4'h0) begin errors++; $display("FAIL unmapped_f18 got %h exp %h", bus.cpu_rdata, 4'h0); end
    bus.cpu_addr = 12'hEFF; #1;
    checks++; if (bus.cpu_rdata !== 4'hA) begin errors++; $display("FAIL below_page_ext got %h exp %h", bus.cpu_rdata, 4'hA); end
    bus.cpu_addr = 12'h000;
  endtask

  task automatic test_reset_mid_store();
    bus.cpu_addr = 12'h200; bus.cpu_rw = 1'b1; bus.cpu_wdata = 4'h1;
    step();
    bus.cpu_wdata = 4'h2; rst_n = 1'b0; #1;
    checks++; if (bus.ext_we !== 1'b0) begin errors++; $display("FAIL rst_ext_we got %b exp %b", bus.ext_we, 1'b0); end
    step();
    rst_n = 1'b1;
    bus.cpu_addr = 12'hF08; bus.cpu_wdata = 4'h3;
    step();
    bus.cpu_wdata = 4'h7; rst_n = 1'b0;
    step();
    rst_n = 1'b1; bus.cpu_rw = 1'b0; #1;
    checks++; if (bus.cpu_rdata !== 4'h0) begin errors++; $display("FAIL rst_store_abandoned got %h exp %h", bus.cpu_rdata, 4'h0); end
    bus.cpu_addr = 12'hF07; #1;
    checks++; if (bus.cpu_rdata !== 4'h0) begin errors++; $display("FAIL rst_ram_cleared got %h exp %h", bus.cpu_rdata, 4'h0); end
    checks++; if (gpio_out !== 4'h0) begin errors++; $display("FAIL rst_gpio_cleared got %h exp %h", gpio_out, 4'h0); end
    bus.cpu_addr = 12'h000;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ram_store();
    test_ext_store();
    test_timer();
    test_snapshot();
    test_gpio();
    test_unmapped();
    test_reset_mid_store();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
